vga_sync_gen_mm: RTL and testbench
==================================

Name: vga_sync_gen_mm

Overview:
Parametrised, dual-mode VGA timing generator. It replaces the fixed 800x600 generator used by the text/SDR display path. It produces h_sync, v_sync, pixel coordinates, blanking, and line/frame start strobes, all registered and mutually aligned. A pixel clock-enable lets one system clock serve several pixel rates. A runtime mode select switches between two timing sets, but only at a frame boundary.

Parameters:
CNT_W, 11, width of internal h/v counters and of h_pos/v_pos (must hold max total-1)
M0_H_ACTIVE/M0_H_FP/M0_H_SYNC/M0_H_BP, 800/56/120/64, mode-0 horizontal timing (pixels)
M0_V_ACTIVE/M0_V_FP/M0_V_SYNC/M0_V_BP, 600/37/6/23, mode-0 vertical timing (lines)
M1_H_ACTIVE/M1_H_FP/M1_H_SYNC/M1_H_BP, 640/16/96/48, mode-1 horizontal timing
M1_V_ACTIVE/M1_V_FP/M1_V_SYNC/M1_V_BP, 480/10/2/33, mode-1 vertical timing
M0_SYNC_POL, 0, mode-0 sync polarity (0 = active-low, 1 = active-high), applies to both h and v
M1_SYNC_POL, 0, mode-1 sync polarity

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_ce  in  1  pixel clock enable; all timing advances only on cycles with pix_ce=1
mode_sel  in  1  requested timing mode (0/1); sampled only at frame boundary or reset
h_sync  out  1  horizontal sync, polarity per active mode
v_sync  out  1  vertical sync, polarity per active mode
h_pos  out  CNT_W  active-region column; 0 while blanking
v_pos  out  CNT_W  active-region row; 0 while blanking
blanking  out  1  1 outside the active region
line_start  out  1  one-clk pulse on the first pixel of every line (h count 0)
frame_start  out  1  one-clk pulse on the first pixel of every frame (h=0, v=0)
active_mode  out  1  mode currently being generated

Behaviour:
- Reset (reset=1 at a clk edge): h_cnt=0, v_cnt=0, active_mode<=mode_sel. Outputs: h_sync=v_sync=~SYNC_POL(mode_sel), blanking=1, h_pos=v_pos=0, line_start=frame_start=0. Reset overrides pix_ce and takes effect mid-frame without completing the frame.
- Totals per mode: H_MAX = ACTIVE+FP+SYNC+BP; V_MAX likewise. Mode 0 is 1040x666; mode 1 is 800x525.
- Counter advance happens on clk edges with pix_ce=1:
  - h_cnt==H_MAX-1: h_cnt<=0; v_cnt wraps to 0 if v_cnt==V_MAX-1, else increments.
  - Otherwise h_cnt increments.
  - With pix_ce=0, all state and outputs hold, except line_start and frame_start, which are forced to 0.
- Mode switch: on the ce-cycle where h_cnt==H_MAX-1 and v_cnt==V_MAX-1, active_mode<=mode_sel. The next frame uses the new timing from count (0,0). Changes of mode_sel at any other time have no effect. No partial frames are produced.
- Output decode is a single registered stage. On each ce-cycle, outputs reflect the counter value present before that edge, so latency is 1 ce-cycle from counter to all outputs, with all outputs aligned.
  - h_sync = SYNC_POL when H_ACTIVE+FP <= h_cnt < H_ACTIVE+FP+SYNC, else ~SYNC_POL. v_sync is analogous on v_cnt. No early-by-one offset.
  - blanking = !(h_cnt<H_ACTIVE && v_cnt<V_ACTIVE).
  - h_pos = h_cnt and v_pos = v_cnt when not blanking, else 0.
  - line_start = (h_cnt==0); frame_start = (h_cnt==0 && v_cnt==0). Both are qualified by pix_ce, so each is exactly one clk wide.
- On the cycle after a mode switch, decode uses the new mode's parameters and polarity.
- Comparisons are unsigned, at CNT_W bits. Elaboration-time check: every mode's H_MAX-1 and V_MAX-1 must fit in CNT_W, else $error.
- pix_ce held at 1 gives one pixel per clk, which is the existing 50 MHz mode-0 behaviour.

Decomposition:
- Package vga_timing_pkg holds:
  - a typedef struct for one mode's timing (active, fp, sync, bp, pol, for h and v);
  - a function computing totals and sync start/end;
  - the default mode-0/mode-1 constants.
- Sub-module sync_axis_timer is instantiated twice (h and v). Inputs: advance, selected timing fields. Outputs: count, wrap, sync_n/p, active. The h instance's wrap drives the v instance's advance.

Test Plan:
1. reset held 3 clks, mode_sel=0, pix_ce=1, then released -> after 1 clk frame_start=1 and line_start=1, blanking=0, h_pos=v_pos=0. h_sync first goes low at clk 857 after release (pixel 856), stays low 120 clks. Line period 1040 clks, frame period 692640 clks.
2. mode_sel=0, pix_ce toggling 1/0 every clk -> all periods double. line_start and frame_start remain 1 clk wide. Outputs hold on ce=0 cycles.
3. Flip mode_sel to 1 at mid-frame (v=300) -> mode-0 frame completes unchanged. active_mode=1 coincides with the next frame_start. Subsequent lines are 800 ce-cycles, frames 525 lines, h_sync low for 96 pixels starting at h=656.
4. Mode 1 with M1_SYNC_POL=1 (overridden) -> h_sync and v_sync idle low and pulse high. After reset, both read 0.
5. Assert reset at mode 1, h=400, v=200 -> next clk all outputs at reset values and counters at 0. Following frame uses the mode_sel sampled at reset.
6. Boundary scan over a full mode-0 frame -> blanking=0 exactly for h<800 and v<600 (480000 ce-cycles per frame). Max h_pos=799, max v_pos=599. v_sync low exactly for v in 637..642.

Source files
------------

// File: rtl/vga_sync_gen_mm_pkg.sv
// Timing types, default mode constants and the limit calculation shared by
// the VGA timing generator and its per-axis counter.
package vga_timing_pkg;

   localparam int TIM_W = 16;

   typedef struct packed {
      logic [TIM_W-1:0] h_active;
      logic [TIM_W-1:0] h_fp;
      logic [TIM_W-1:0] h_sync;
      logic [TIM_W-1:0] h_bp;
      logic [TIM_W-1:0] v_active;
      logic [TIM_W-1:0] v_fp;
      logic [TIM_W-1:0] v_sync;
      logic [TIM_W-1:0] v_bp;
      logic             pol;
   } mode_timing_t;

   typedef struct packed {
      logic [TIM_W-1:0] active;
      logic [TIM_W-1:0] sync_start;
      logic [TIM_W-1:0] sync_end;
      logic [TIM_W-1:0] total;
   } axis_lim_t;

   localparam mode_timing_t MODE0_DEF = '{
      h_active: 16'd800, h_fp: 16'd56, h_sync: 16'd120, h_bp: 16'd64,
      v_active: 16'd600, v_fp: 16'd37, v_sync: 16'd6,   v_bp: 16'd23,
      pol: 1'b0};

   localparam mode_timing_t MODE1_DEF = '{
      h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
      v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33,
      pol: 1'b0};

   // Sync window is [sync_start, sync_end); the front porch follows the active area.
   function automatic axis_lim_t axis_limits(input logic [TIM_W-1:0] active,
                                             input logic [TIM_W-1:0] fp,
                                             input logic [TIM_W-1:0] sync,
                                             input logic [TIM_W-1:0] bp);
      axis_lim_t l;
      l.active     = active;
      l.sync_start = active + fp;
      l.sync_end   = active + fp + sync;
      l.total      = active + fp + sync + bp;
      return l;
   endfunction

endpackage

// File: rtl/vga_sync_gen_mm_if.sv
// Control inputs and timing outputs of the VGA sync generator.
interface vga_sync_gen_mm_if #(parameter int CNT_W = 11);
   logic             pix_ce;
   logic             mode_sel;
   logic             h_sync;
   logic             v_sync;
   logic [CNT_W-1:0] h_pos;
   logic [CNT_W-1:0] v_pos;
   logic             blanking;
   logic             line_start;
   logic             frame_start;
   logic             active_mode;

   modport master (
      input  pix_ce, mode_sel,
      output h_sync, v_sync, h_pos, v_pos, blanking, line_start, frame_start, active_mode
   );

   modport slave (
      output pix_ce, mode_sel,
      input  h_sync, v_sync, h_pos, v_pos, blanking, line_start, frame_start, active_mode
   );
endinterface

// File: rtl/vga_sync_gen_mm_sync_axis_timer.sv
// One timing axis: wrapping counter plus combinational sync/active window flags.
module sync_axis_timer #(
   parameter int CNT_W = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             advance,
   input  logic [CNT_W-1:0] total_m1,
   input  logic [CNT_W-1:0] active_len,
   input  logic [CNT_W-1:0] sync_start,
   input  logic [CNT_W-1:0] sync_end,
   output logic [CNT_W-1:0] count,
   output logic             wrap,
   output logic             sync_p,
   output logic             sync_n,
   output logic             active
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign wrap   = advance && (cnt_q == total_m1);
   assign sync_p = (cnt_q >= sync_start) && (cnt_q < sync_end);
   assign sync_n = ~sync_p;
   assign active = cnt_q < active_len;
   assign count  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (wrap) begin
         cnt_d = '0;
      end else if (advance) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/vga_sync_gen_mm.sv
// Dual-mode VGA timing generator with pixel clock-enable; mode changes are
// taken only at the end of a frame so no partial frames are emitted.
module vga_sync_gen_mm
   import vga_timing_pkg::*;
#(
   parameter int          CNT_W       = 11,
   parameter int unsigned M0_H_ACTIVE = 800,
   parameter int unsigned M0_H_FP     = 56,
   parameter int unsigned M0_H_SYNC   = 120,
   parameter int unsigned M0_H_BP     = 64,
   parameter int unsigned M0_V_ACTIVE = 600,
   parameter int unsigned M0_V_FP     = 37,
   parameter int unsigned M0_V_SYNC   = 6,
   parameter int unsigned M0_V_BP     = 23,
   parameter int unsigned M1_H_ACTIVE = 640,
   parameter int unsigned M1_H_FP     = 16,
   parameter int unsigned M1_H_SYNC   = 96,
   parameter int unsigned M1_H_BP     = 48,
   parameter int unsigned M1_V_ACTIVE = 480,
   parameter int unsigned M1_V_FP     = 10,
   parameter int unsigned M1_V_SYNC   = 2,
   parameter int unsigned M1_V_BP     = 33,
   parameter bit          M0_SYNC_POL = MODE0_DEF.pol,
   parameter bit          M1_SYNC_POL = MODE1_DEF.pol
) (
   input logic              clk,
   input logic              reset,
   vga_sync_gen_mm_if.master bus
);

   localparam axis_lim_t M0_H = axis_limits(TIM_W'(M0_H_ACTIVE), TIM_W'(M0_H_FP),
                                            TIM_W'(M0_H_SYNC), TIM_W'(M0_H_BP));
   localparam axis_lim_t M0_V = axis_limits(TIM_W'(M0_V_ACTIVE), TIM_W'(M0_V_FP),
                                            TIM_W'(M0_V_SYNC), TIM_W'(M0_V_BP));
   localparam axis_lim_t M1_H = axis_limits(TIM_W'(M1_H_ACTIVE), TIM_W'(M1_H_FP),
                                            TIM_W'(M1_H_SYNC), TIM_W'(M1_H_BP));
   localparam axis_lim_t M1_V = axis_limits(TIM_W'(M1_V_ACTIVE), TIM_W'(M1_V_FP),
                                            TIM_W'(M1_V_SYNC), TIM_W'(M1_V_BP));

   localparam int CNT_SPAN = 1 << CNT_W;

   if (int'(M0_H.total) > CNT_SPAN || int'(M0_V.total) > CNT_SPAN ||
       int'(M1_H.total) > CNT_SPAN || int'(M1_V.total) > CNT_SPAN) begin : g_cnt_w_check
      $error("vga_sync_gen_mm: CNT_W too small for configured timing totals");
   end

   logic mode_q, mode_d;
   logic h_sync_q, h_sync_d;
   logic v_sync_q, v_sync_d;
   logic [CNT_W-1:0] h_pos_q, h_pos_d;
   logic [CNT_W-1:0] v_pos_q, v_pos_d;
   logic blanking_q, blanking_d;
   logic line_start_q, line_start_d;
   logic frame_start_q, frame_start_d;
   logic active_mode_q, active_mode_d;

   axis_lim_t h_lim, v_lim;
   logic      pol;

   always_comb begin
      h_lim = mode_q ? M1_H : M0_H;
      v_lim = mode_q ? M1_V : M0_V;
      pol   = mode_q ? M1_SYNC_POL : M0_SYNC_POL;
   end

   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic h_wrap, v_wrap;
   logic h_sp, h_sn, v_sp, v_sn;
   logic h_act, v_act;

   sync_axis_timer #(.CNT_W(CNT_W)) u_h_timer (
      .clk       (clk),
      .rst       (reset),
      .advance   (bus.pix_ce),
      .total_m1  (CNT_W'(h_lim.total - 1'b1)),
      .active_len(CNT_W'(h_lim.active)),
      .sync_start(CNT_W'(h_lim.sync_start)),
      .sync_end  (CNT_W'(h_lim.sync_end)),
      .count     (h_cnt),
      .wrap      (h_wrap),
      .sync_p    (h_sp),
      .sync_n    (h_sn),
      .active    (h_act)
   );

   sync_axis_timer #(.CNT_W(CNT_W)) u_v_timer (
      .clk       (clk),
      .rst       (reset),
      .advance   (h_wrap),
      .total_m1  (CNT_W'(v_lim.total - 1'b1)),
      .active_len(CNT_W'(v_lim.active)),
      .sync_start(CNT_W'(v_lim.sync_start)),
      .sync_end  (CNT_W'(v_lim.sync_end)),
      .count     (v_cnt),
      .wrap      (v_wrap),
      .sync_p    (v_sp),
      .sync_n    (v_sn),
      .active    (v_act)
   );

   // Decode stage: outputs reflect the counters as they were before this edge.
   always_comb begin
      mode_d        = mode_q;
      h_sync_d      = h_sync_q;
      v_sync_d      = v_sync_q;
      h_pos_d       = h_pos_q;
      v_pos_d       = v_pos_q;
      blanking_d    = blanking_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      active_mode_d = active_mode_q;
      if (bus.pix_ce) begin
         h_sync_d      = pol ? h_sp : h_sn;
         v_sync_d      = pol ? v_sp : v_sn;
         blanking_d    = !(h_act && v_act);
         h_pos_d       = (h_act && v_act) ? h_cnt : '0;
         v_pos_d       = (h_act && v_act) ? v_cnt : '0;
         line_start_d  = (h_cnt == '0);
         frame_start_d = (h_cnt == '0) && (v_cnt == '0);
         active_mode_d = mode_q;
         if (v_wrap) begin
            mode_d = bus.mode_sel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q        <= bus.mode_sel;
         h_sync_q      <= bus.mode_sel ? ~M1_SYNC_POL : ~M0_SYNC_POL;
         v_sync_q      <= bus.mode_sel ? ~M1_SYNC_POL : ~M0_SYNC_POL;
         h_pos_q       <= '0;
         v_pos_q       <= '0;
         blanking_q    <= 1'b1;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         active_mode_q <= bus.mode_sel;
      end else begin
         mode_q        <= mode_d;
         h_sync_q      <= h_sync_d;
         v_sync_q      <= v_sync_d;
         h_pos_q       <= h_pos_d;
         v_pos_q       <= v_pos_d;
         blanking_q    <= blanking_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         active_mode_q <= active_mode_d;
      end
   end

   assign bus.h_sync      = h_sync_q;
   assign bus.v_sync      = v_sync_q;
   assign bus.h_pos       = h_pos_q;
   assign bus.v_pos       = v_pos_q;
   assign bus.blanking    = blanking_q;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;
   assign bus.active_mode = active_mode_q;

endmodule

// File: tb/tb_vga_sync_gen_mm.sv
// Bench for vga_sync_gen_mm using shrunken timings and a frame-position reference model.
module tb_vga_sync_gen_mm;

   localparam int CNT_W = 11;
   // Per-mode timings: index 0 = mode 0, 1 = mode 1 (mode 1 uses active-high sync).
   localparam int HA[2] = '{8, 5};
   localparam int HF[2] = '{2, 1};
   localparam int HS[2] = '{3, 2};
   localparam int HB[2] = '{2, 3};
   localparam int VA[2] = '{6, 4};
   localparam int VF[2] = '{1, 2};
   localparam int VS[2] = '{2, 1};
   localparam int VB[2] = '{1, 2};
   localparam bit POL[2] = '{1'b0, 1'b1};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vga_sync_gen_mm_if #(.CNT_W(CNT_W)) bus ();

   vga_sync_gen_mm #(
      .CNT_W(CNT_W),
      .M0_H_ACTIVE(HA[0]), .M0_H_FP(HF[0]), .M0_H_SYNC(HS[0]), .M0_H_BP(HB[0]),
      .M0_V_ACTIVE(VA[0]), .M0_V_FP(VF[0]), .M0_V_SYNC(VS[0]), .M0_V_BP(VB[0]),
      .M1_H_ACTIVE(HA[1]), .M1_H_FP(HF[1]), .M1_H_SYNC(HS[1]), .M1_H_BP(HB[1]),
      .M1_V_ACTIVE(VA[1]), .M1_V_FP(VF[1]), .M1_V_SYNC(VS[1]), .M1_V_BP(VB[1]),
      .M0_SYNC_POL(POL[0]), .M1_SYNC_POL(POL[1])
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model state: linear pixel index within the current frame and its mode.
   int pos  = 0;
   int mode = 0;
   bit e_hs, e_vs, e_bl, e_ls, e_fs, e_am;
   int e_hp, e_vp;

   task automatic model_step(input bit r, input bit ce, input bit ms);
      int h, v, ht, vt;
      if (r) begin
         pos  = 0;
         mode = int'(ms);
         e_hs = ~POL[ms]; e_vs = ~POL[ms];
         e_bl = 1'b1; e_hp = 0; e_vp = 0;
         e_ls = 1'b0; e_fs = 1'b0; e_am = ms;
      end else if (ce) begin
         ht = HA[mode] + HF[mode] + HS[mode] + HB[mode];
         vt = VA[mode] + VF[mode] + VS[mode] + VB[mode];
         h = pos % ht;
         v = pos / ht;
         e_hs = (h >= HA[mode] + HF[mode] && h < HA[mode] + HF[mode] + HS[mode]) ? POL[mode] : ~POL[mode];
         e_vs = (v >= VA[mode] + VF[mode] && v < VA[mode] + VF[mode] + VS[mode]) ? POL[mode] : ~POL[mode];
         e_bl = !(h < HA[mode] && v < VA[mode]);
         e_hp = e_bl ? 0 : h;
         e_vp = e_bl ? 0 : v;
         e_ls = (h == 0);
         e_fs = (pos == 0);
         e_am = mode[0];
         pos++;
         if (pos == ht * vt) begin
            pos  = 0;
            mode = int'(ms);
         end
      end else begin
         e_ls = 1'b0;
         e_fs = 1'b0;
      end
   endtask

   task automatic cycle(input bit r, input bit ce, input bit ms);
      @(negedge clk);
      reset        = r;
      bus.pix_ce   = ce;
      bus.mode_sel = ms;
      @(posedge clk);
      model_step(r, ce, ms);
      #1;
      chk("h_sync",      32'(bus.h_sync),      32'(e_hs));
      chk("v_sync",      32'(bus.v_sync),      32'(e_vs));
      chk("blanking",    32'(bus.blanking),    32'(e_bl));
      chk("h_pos",       32'(bus.h_pos),       32'(e_hp));
      chk("v_pos",       32'(bus.v_pos),       32'(e_vp));
      chk("line_start",  32'(bus.line_start),  32'(e_ls));
      chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
      chk("active_mode", 32'(bus.active_mode), 32'(e_am));
   endtask

   initial begin
      int nonblank, max_hp, max_vp, vs_low, frame_cyc;
      bit ms;
      reset        = 1'b1;
      bus.pix_ce   = 1'b1;
      bus.mode_sel = 1'b0;

      // Reset held 3 clocks, then the first decoded pixel of a frame.
      repeat (3) cycle(1'b1, 1'b1, 1'b0);
      chk("rst_blanking", 32'(bus.blanking), 32'd1);
      chk("rst_h_sync",   32'(bus.h_sync),   32'd1);
      cycle(1'b0, 1'b1, 1'b0);
      chk("first_frame_start", 32'(bus.frame_start), 32'd1);
      chk("first_line_start",  32'(bus.line_start),  32'd1);
      chk("first_blanking",    32'(bus.blanking),    32'd0);

      // Boundary scan over the rest of one full mode-0 frame.
      frame_cyc = (HA[0] + HF[0] + HS[0] + HB[0]) * (VA[0] + VF[0] + VS[0] + VB[0]);
      nonblank = 1; max_hp = 0; max_vp = 0; vs_low = 0;
      for (int i = 1; i < frame_cyc; i++) begin
         cycle(1'b0, 1'b1, 1'b0);
         if (!bus.blanking) nonblank++;
         if (int'(bus.h_pos) > max_hp) max_hp = int'(bus.h_pos);
         if (int'(bus.v_pos) > max_vp) max_vp = int'(bus.v_pos);
         if (!bus.v_sync) vs_low++;
      end
      chk("scan_nonblank", 32'(nonblank), 32'(HA[0] * VA[0]));
      chk("scan_max_hpos", 32'(max_hp),   32'(HA[0] - 1));
      chk("scan_max_vpos", 32'(max_vp),   32'(VA[0] - 1));
      chk("scan_vs_low",   32'(vs_low),   32'(VS[0] * (HA[0] + HF[0] + HS[0] + HB[0])));

      // pix_ce toggling every clock for two mode-0 frames.
      for (int i = 0; i < 4 * frame_cyc; i++) cycle(1'b0, i[0] == 1'b0, 1'b0);

      // Mid-frame request for mode 1; current frame must finish in mode 0.
      for (int i = 0; i < frame_cyc / 2; i++) cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3 * frame_cyc; i++) cycle(1'b0, 1'b1, 1'b1);

      // Reset with mode 1 selected: active-high sync idles low.
      cycle(1'b1, 1'b1, 1'b1);
      chk("rst_m1_h_sync", 32'(bus.h_sync), 32'd0);
      chk("rst_m1_v_sync", 32'(bus.v_sync), 32'd0);
      chk("rst_m1_mode",   32'(bus.active_mode), 32'd1);

      // Randomized pix_ce, mode_sel flips and occasional mid-frame resets.
      ms = 1'b1;
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 59) == 0) ms = ~ms;
         cycle($urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0, ms);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
